xaui_link_monitor: RTL and testbench



---
 rtl/xaui_link_monitor_pkg.sv | 40 ++++
 rtl/xaui_link_monitor_if.sv | 23 ++
 rtl/xaui_link_qual.sv | 43 ++++
 rtl/xaui_link_monitor.sv | 116 +++++++++++
 tb/tb_xaui_link_monitor.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/xaui_link_monitor_pkg.sv
// Shared constants, state encoding and helpers for the XAUI link monitor.
package xaui_link_monitor_pkg;

    localparam int unsigned STATUS_W = 8;
    localparam int unsigned RETRY_W  = 4;
    localparam int unsigned FLAP_W   = 16;

    // xaui_status bit positions
    localparam int unsigned TX_LFAULT = 0;
    localparam int unsigned RX_LFAULT = 1;
    localparam int unsigned SYNC_LO   = 2;
    localparam int unsigned SYNC_HI   = 5;
    localparam int unsigned ALIGN     = 6;
    localparam int unsigned RX_LINK   = 7;

    // one-hot state bit positions
    localparam int unsigned ST_RST    = 0;
    localparam int unsigned ST_WAIT   = 1;
    localparam int unsigned ST_STABLE = 2;
    localparam int unsigned ST_UP     = 3;
    localparam int unsigned ST_LOSS   = 4;
    localparam int unsigned ST_W      = 5;

    typedef enum logic [ST_W-1:0] {
        S_RST    = ST_W'(1) << ST_RST,
        S_WAIT   = ST_W'(1) << ST_WAIT,
        S_STABLE = ST_W'(1) << ST_STABLE,
        S_UP     = ST_W'(1) << ST_UP,
        S_LOSS   = ST_W'(1) << ST_LOSS
    } state_e;

    function automatic logic [RETRY_W-1:0] sat_inc_retry(input logic [RETRY_W-1:0] v);
        return (&v) ? v : v + RETRY_W'(1);
    endfunction

    function automatic logic [FLAP_W-1:0] sat_inc_flap(input logic [FLAP_W-1:0] v);
        return (&v) ? v : v + FLAP_W'(1);
    endfunction

endpackage

// File: rtl/xaui_link_monitor_if.sv
// Status input, reset request and statistics of the XAUI link monitor.
interface xaui_link_monitor_if;
    import xaui_link_monitor_pkg::*;

    logic [STATUS_W-1:0] xaui_status;
    logic [STATUS_W-1:0] status_reg;
    logic                xaui_reset;
    logic                link_up;
    logic                link_drop;
    logic [RETRY_W-1:0]  retry_cnt;
    logic [FLAP_W-1:0]   flap_cnt;

    // status_reg exposes the registered status (including fault/link bits) to the register map
    modport master (
        input  xaui_status,
        output status_reg, xaui_reset, link_up, link_drop, retry_cnt, flap_cnt
    );

    modport slave (
        output xaui_status,
        input  status_reg, xaui_reset, link_up, link_drop, retry_cnt, flap_cnt
    );
endinterface

// File: rtl/xaui_link_qual.sv
// Status input register, link-good decode and shared interval counter with terminal compares.
module xaui_link_qual
    import xaui_link_monitor_pkg::*;
#(
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned ALIGN_TIMEOUT = 1000000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned LOSS_CYCLES   = 8,
    parameter int unsigned CNT_W         = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [STATUS_W-1:0] status,
    input  logic                clr,
    output logic [STATUS_W-1:0] status_q,
    output logic                good_c,
    output logic                rst_done_c,
    output logic                wait_to_c,
    output logic                stable_done_c,
    output logic                loss_done_c
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
            cnt      <= '0;
        end else begin
            status_q <= status;
            cnt      <= clr ? '0 : cnt + CNT_W'(1);
        end
    end

    // all lanes synced, aligned, and no receive-side local fault
    assign good_c = (&status_q[SYNC_HI:SYNC_LO]) & status_q[ALIGN] & ~status_q[RX_LFAULT];

    assign rst_done_c    = (cnt == CNT_W'(RESET_CYCLES - 1));
    assign wait_to_c     = (cnt == CNT_W'(ALIGN_TIMEOUT - 1));
    assign stable_done_c = (cnt == CNT_W'(STABLE_CYCLES - 1));
    assign loss_done_c   = (cnt == CNT_W'(LOSS_CYCLES - 1));

endmodule

// File: rtl/xaui_link_monitor.sv
// Link bring-up FSM: holds the XAUI core in reset, qualifies link, retries and counts flaps.
module xaui_link_monitor
    import xaui_link_monitor_pkg::*;
#(
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned ALIGN_TIMEOUT = 1000000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned LOSS_CYCLES   = 8,
    parameter int unsigned CNT_W         = 24
) (
    input  logic                clk156_25,
    input  logic                reset156_25_n,
    xaui_link_monitor_if.master bus
);

    state_e              state, state_nxt;
    logic                clr_c;
    logic                good_c, rst_done_c, wait_to_c, stable_done_c, loss_done_c;
    logic [STATUS_W-1:0] status_q;
    logic                xaui_reset_q, link_up_q, link_drop_q;
    logic                link_up_nxt, link_drop_nxt;
    logic [RETRY_W-1:0]  retry_q, retry_nxt;
    logic [FLAP_W-1:0]   flap_q, flap_nxt;

    assign clr_c = (state_nxt != state);

    xaui_link_qual #(
        .RESET_CYCLES  (RESET_CYCLES),
        .ALIGN_TIMEOUT (ALIGN_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .LOSS_CYCLES   (LOSS_CYCLES),
        .CNT_W         (CNT_W)
    ) u_qual (
        .clk           (clk156_25),
        .rst_n         (reset156_25_n),
        .status        (bus.xaui_status),
        .clr           (clr_c),
        .status_q      (status_q),
        .good_c        (good_c),
        .rst_done_c    (rst_done_c),
        .wait_to_c     (wait_to_c),
        .stable_done_c (stable_done_c),
        .loss_done_c   (loss_done_c)
    );

    always_ff @(posedge clk156_25 or negedge reset156_25_n) begin
        if (!reset156_25_n) begin
            state        <= S_RST;
            xaui_reset_q <= 1'b1;
            link_up_q    <= 1'b0;
            link_drop_q  <= 1'b0;
            retry_q      <= '0;
            flap_q       <= '0;
        end else begin
            state        <= state_nxt;
            xaui_reset_q <= (state_nxt == S_RST);
            link_up_q    <= link_up_nxt;
            link_drop_q  <= link_drop_nxt;
            retry_q      <= retry_nxt;
            flap_q       <= flap_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        link_up_nxt   = link_up_q;
        link_drop_nxt = 1'b0;
        retry_nxt     = retry_q;
        flap_nxt      = flap_q;
        case (state)
            S_RST: begin
                if (rst_done_c) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // a good sample wins over a coincident timeout
                if (good_c) begin
                    state_nxt = S_STABLE;
                end else if (wait_to_c) begin
                    state_nxt = S_RST;
                    retry_nxt = sat_inc_retry(retry_q);
                end
            end
            S_STABLE: begin
                if (!good_c) begin
                    state_nxt = S_WAIT;
                end else if (stable_done_c) begin
                    state_nxt   = S_UP;
                    link_up_nxt = 1'b1;
                    retry_nxt   = '0;
                end
            end
            S_UP: begin
                if (!good_c) state_nxt = S_LOSS;
            end
            S_LOSS: begin
                if (good_c) begin
                    state_nxt = S_UP;
                end else if (loss_done_c) begin
                    state_nxt     = S_RST;
                    link_up_nxt   = 1'b0;
                    link_drop_nxt = 1'b1;
                    flap_nxt      = sat_inc_flap(flap_q);
                end
            end
            default: state_nxt = S_RST;
        endcase
    end

    assign bus.status_reg = status_q;
    assign bus.xaui_reset = xaui_reset_q;
    assign bus.link_up    = link_up_q;
    assign bus.link_drop  = link_drop_q;
    assign bus.retry_cnt  = retry_q;
    assign bus.flap_cnt   = flap_q;

endmodule

// File: tb/tb_xaui_link_monitor.sv
// Directed bench for xaui_link_monitor with a run-length reference model checked every cycle.
module tb_xaui_link_monitor;

    localparam int RC = 4;
    localparam int AT = 32;
    localparam int SC = 8;
    localparam int LC = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    xaui_link_monitor_if bus ();

    xaui_link_monitor #(
        .RESET_CYCLES  (RC),
        .ALIGN_TIMEOUT (AT),
        .STABLE_CYCLES (SC),
        .LOSS_CYCLES   (LC),
        .CNT_W         (24)
    ) dut (
        .clk156_25     (clk),
        .reset156_25_n (rst_n),
        .bus           (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = core held in reset, 1 = hunting for link, 2 = link up.
    // Hunting tracks consecutive good samples (S+1 needed) and unbroken waiting bad samples (T -> retry);
    // up tracks consecutive bad samples (L+1 -> drop).
    logic [7:0] m_sq = '0;
    int phase = 0, r = 0, good_run = 0, bad_run = 0, lbad_run = 0;
    int m_retry = 0, m_flap = 0;
    bit m_reset = 1'b1, m_up = 1'b0, m_drop = 1'b0, g;

    function automatic bit link_good(input logic [7:0] s);
        return (s[5:2] == 4'hF) && s[6] && !s[1];
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_sq = '0; phase = 0; r = 0; good_run = 0; bad_run = 0; lbad_run = 0;
                m_retry = 0; m_flap = 0; m_reset = 1'b1; m_up = 1'b0; m_drop = 1'b0;
            end else begin
                g = link_good(m_sq);
                m_drop = 1'b0;
                case (phase)
                    0: if (r == RC - 1) begin phase = 1; good_run = 0; bad_run = 0; end
                       else r++;
                    1: if (g) begin
                           good_run++; bad_run = 0;
                           if (good_run == SC + 1) begin
                               phase = 2; m_up = 1'b1; m_retry = 0; lbad_run = 0;
                           end
                       end else if (good_run > 0) begin
                           good_run = 0; bad_run = 0;
                       end else begin
                           bad_run++;
                           if (bad_run == AT) begin
                               phase = 0; r = 0;
                               m_retry = (m_retry < 15) ? m_retry + 1 : 15;
                           end
                       end
                    default: if (g) lbad_run = 0;
                       else begin
                           lbad_run++;
                           if (lbad_run == LC + 1) begin
                               phase = 0; r = 0; m_up = 1'b0; m_drop = 1'b1;
                               m_flap = (m_flap < 65535) ? m_flap + 1 : 65535;
                           end
                       end
                endcase
                m_reset = (phase == 0);
                m_sq = bus.xaui_status;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_xaui_reset", 32'(bus.xaui_reset), 32'(m_reset));
            check("model_link_up",    32'(bus.link_up),    32'(m_up));
            check("model_link_drop",  32'(bus.link_drop),  32'(m_drop));
            check("model_retry_cnt",  32'(bus.retry_cnt),  32'(m_retry));
            check("model_flap_cnt",   32'(bus.flap_cnt),   32'(m_flap));
            check("model_status_reg", 32'(bus.status_reg), 32'(m_sq));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_xaui_reset"}, 32'(bus.xaui_reset), 32'd1);
        check({tag, "_link_up"},    32'(bus.link_up),    32'd0);
        check({tag, "_link_drop"},  32'(bus.link_drop),  32'd0);
        check({tag, "_retry"},      32'(bus.retry_cnt),  32'd0);
        check({tag, "_flap"},       32'(bus.flap_cnt),   32'd0);
    endtask

    initial begin
        bus.xaui_status = 8'h00;
        #12;
        check_reset_values("por");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // reset pulse of RC clocks, then timeouts every AT+RC clocks
        tick(3);  check("rst_pulse_hi", 32'(bus.xaui_reset), 32'd1);
        tick(1);  check("rst_pulse_lo", 32'(bus.xaui_reset), 32'd0);
        tick(31); check("wait_no_retry", 32'(bus.xaui_reset), 32'd0);
        tick(1);  check("timeout1_reset", 32'(bus.xaui_reset), 32'd1);
                  check("timeout1_retry", 32'(bus.retry_cnt), 32'd1);
        tick(36); check("timeout2_retry", 32'(bus.retry_cnt), 32'd2);
        tick(36 * 14); check("timeout16_retry", 32'(bus.retry_cnt), 32'd15);
        tick(36); check("retry_saturated", 32'(bus.retry_cnt), 32'd15);

        // link bring-up: link_up exactly 10 clocks after status becomes good
        tick(4);  check("released_again", 32'(bus.xaui_reset), 32'd0);
        bus.xaui_status = 8'h7C;
        tick(9);  check("up_not_yet", 32'(bus.link_up), 32'd0);
        tick(1);  check("up_at_10", 32'(bus.link_up), 32'd1);
                  check("up_retry_clr", 32'(bus.retry_cnt), 32'd0);
                  check("up_reset_low", 32'(bus.xaui_reset), 32'd0);

        // short glitch is absorbed
        bus.xaui_status = 8'h00; tick(2);
        bus.xaui_status = 8'hFD; tick(10);
        check("glitch_up", 32'(bus.link_up), 32'd1);
        check("glitch_flap", 32'(bus.flap_cnt), 32'd0);

        // sustained loss: drop pulse, then a fresh reset pulse
        bus.xaui_status = 8'h00;
        tick(4);  check("loss_no_drop_yet", 32'(bus.link_drop), 32'd0);
                  check("loss_still_up", 32'(bus.link_up), 32'd1);
        tick(1);  check("drop_pulse", 32'(bus.link_drop), 32'd1);
                  check("drop_link_down", 32'(bus.link_up), 32'd0);
                  check("drop_flap", 32'(bus.flap_cnt), 32'd1);
                  check("drop_reset_hi", 32'(bus.xaui_reset), 32'd1);
                  check("drop_retry", 32'(bus.retry_cnt), 32'd0);
        tick(1);  check("drop_one_cycle", 32'(bus.link_drop), 32'd0);
        tick(2);  check("drop_reset_still_hi", 32'(bus.xaui_reset), 32'd1);
        tick(1);  check("drop_reset_released", 32'(bus.xaui_reset), 32'd0);

        // rx_local_fault chatter keeps restarting qualification and timeout
        for (int i = 0; i < 12; i++) begin
            bus.xaui_status = (i % 2 == 0) ? 8'h7C : 8'h7E;
            tick(5);
            check("chatter_no_up", 32'(bus.link_up), 32'd0);
        end
        check("chatter_no_retry", 32'(bus.retry_cnt), 32'd0);
        tick(40);
        check("fault_timeout_retry", 32'(bus.retry_cnt), 32'd1);

        // async reset mid-s_stable
        bus.xaui_status = 8'h7C;
        tick(4); #2;
        rst_n = 1'b0; #1;
        check_reset_values("async_stable");
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(13); check("reup", 32'(bus.link_up), 32'd1);

        // async reset mid-s_up
        #2;
        rst_n = 1'b0; #1;
        check_reset_values("async_up");
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
